// File: rtl/ir_frame_decoder.sv
// IR pulse-width frame decoder: tick prescaler, input synchroniser, pulse classifier FSM, frame FIFO.
// Optional IR_GLITCH_FILTER_EN adds a GLITCH_TICKS debounce on the sampled level.
module ir_frame_decoder #(
    parameter int DIV_COUNT    = 750,
    parameter int FRAME_BITS   = 12,
    parameter int ZERO_MIN     = 20,
    parameter int ZERO_MAX     = 90,
    parameter int ONE_MIN      = 91,
    parameter int ONE_MAX      = 180,
    parameter int START_MIN    = 181,
    parameter int START_MAX    = 250,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16
`ifdef IR_GLITCH_FILTER_EN
    ,
    parameter int GLITCH_TICKS = 3
`endif
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ir_signal,
    output logic [FRAME_BITS-1:0]         frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   frame_count,
    output logic [15:0]                   error_count,
    output logic [15:0]                   overflow_count,
    output logic                          busy
);

    // state     | meaning
    // HUNT_HIGH | idle, waiting for a falling edge
    // HUNT_LOW  | measuring a candidate start pulse
    // GAP       | inside a frame, measuring high time between pulses
    // MARK      | inside a frame, measuring a data/start low pulse
    typedef enum logic [1:0] {HUNT_HIGH, HUNT_LOW, GAP, MARK} state_t;

    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t state_q, state_d;

    logic [PW-1:0]         presc_q;
    logic                  tick;
    logic                  sync1_q, sync2_q;
    logic                  level_q, level_d;
    logic                  fall, rise;

    logic [CNT_W-1:0]      width_q, width_d, width_inc;
    logic [CNT_W-1:0]      gap_q, gap_d, gap_inc;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d, bitcnt_inc;
    logic                  win_start, win_one, win_zero, last_bit, gap_timeout;
    logic                  push, err_inc;

    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  full, pop, push_ok, ovf;
    logic [31:0]           frame_cnt_q;
    logic [15:0]           err_cnt_q, ovf_cnt_q;

    assign tick = (presc_q == PW'(DIV_COUNT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            sync1_q <= ir_signal;
            sync2_q <= sync1_q;
            level_q <= level_d;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_TICKS + 1);
    logic [GW-1:0] glt_q, glt_d;

    // Level flips only after GLITCH_TICKS consecutive differing samples.
    always_comb begin
        level_d = level_q;
        glt_d   = glt_q;
        if (tick) begin
            if (sync2_q != level_q) begin
                if (glt_q == GW'(GLITCH_TICKS - 1)) begin
                    level_d = sync2_q;
                    glt_d   = '0;
                end else begin
                    glt_d = glt_q + 1'b1;
                end
            end else begin
                glt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) glt_q <= '0;
        else     glt_q <= glt_d;
    end
`else
    assign level_d = tick ? sync2_q : level_q;
`endif

    assign fall = tick &  level_q & ~level_d;
    assign rise = tick & ~level_q &  level_d;

    assign width_inc   = (width_q == '1) ? width_q : width_q + 1'b1;
    assign gap_inc     = (gap_q == '1) ? gap_q : gap_q + 1'b1;
    assign bitcnt_inc  = bitcnt_q + 1'b1;
    assign last_bit    = (bitcnt_inc == BW'(FRAME_BITS));
    assign gap_timeout = (gap_inc >= CNT_W'(IDLE_TIMEOUT));
    assign win_start   = (width_q >= CNT_W'(START_MIN)) && (width_q <= CNT_W'(START_MAX));
    assign win_one     = (width_q >= CNT_W'(ONE_MIN))   && (width_q <= CNT_W'(ONE_MAX));
    assign win_zero    = (width_q >= CNT_W'(ZERO_MIN))  && (width_q <= CNT_W'(ZERO_MAX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= HUNT_HIGH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                HUNT_HIGH: if (fall) state_d = HUNT_LOW;
                HUNT_LOW:  if (rise) state_d = win_start ? GAP : HUNT_HIGH;
                GAP: begin
                    if (fall)             state_d = MARK;
                    else if (gap_timeout) state_d = HUNT_HIGH;
                end
                MARK: begin
                    if (rise) begin
                        if (win_start)                state_d = GAP;
                        else if (win_one || win_zero) state_d = last_bit ? HUNT_HIGH : GAP;
                        else                          state_d = HUNT_HIGH;
                    end
                end
                default: state_d = HUNT_HIGH;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == GAP) || (state_q == MARK);
        width_d  = width_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        push     = 1'b0;
        err_inc  = 1'b0;
        if (tick) begin
            case (state_q)
                HUNT_HIGH: if (fall) width_d = CNT_W'(1);
                HUNT_LOW: begin
                    if (rise) begin
                        if (win_start) begin
                            bitcnt_d = '0;
                            gap_d    = '0;
                        end
                    end else begin
                        width_d = width_inc;
                    end
                end
                GAP: begin
                    if (fall)             width_d = CNT_W'(1);
                    else if (gap_timeout) err_inc = (bitcnt_q != '0);
                    else                  gap_d   = gap_inc;
                end
                MARK: begin
                    if (rise) begin
                        if (win_start) begin
                            err_inc  = (bitcnt_q != '0);
                            bitcnt_d = '0;
                            gap_d    = '0;
                        end else if (win_one || win_zero) begin
                            shift_d  = (shift_q << 1) | FRAME_BITS'(win_one);
                            bitcnt_d = bitcnt_inc;
                            gap_d    = '0;
                            push     = last_bit;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else begin
                        width_d = width_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            width_q  <= '0;
            gap_q    <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            width_q  <= width_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = frame_valid & frame_ready;
    assign push_ok = push & (~full | pop);
    assign ovf     = push & full & ~pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (ovf && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign frame_data     = mem_q[rd_ptr_q];
    assign frame_valid    = (count_q != '0);
    assign fifo_level     = count_q;
    assign frame_count    = frame_cnt_q;
    assign error_count    = err_cnt_q;
    assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Self-checking bench for ir_frame_decoder: pulse-train stimulus, frame scoreboard, counter checks.
module tb_ir_frame_decoder;

    localparam int DIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ir_signal = 1'b1;
    logic        frame_ready = 1'b1;
    logic [11:0] frame_data;
    logic        frame_valid;
    logic [2:0]  fifo_level;
    logic [31:0] frame_count;
    logic [15:0] error_count;
    logic [15:0] overflow_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    ir_frame_decoder #(.DIV_COUNT(DIV)) dut (
        .CLK(CLK), .RST(RST), .ir_signal(ir_signal),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .fifo_level(fifo_level), .frame_count(frame_count), .error_count(error_count),
        .overflow_count(overflow_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Level held for n ticks; always entered and left on a falling CLK edge.
    task automatic drive(input logic v, input int n);
        ir_signal = v;
        repeat (n * DIV) @(negedge CLK);
    endtask

    task automatic send_start();
        drive(1'b0, 200);
        drive(1'b1, 30);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b0, v[i] ? 120 : 50);
            drive(1'b1, 30);
        end
    endtask

    task automatic send_frame(input logic [11:0] v, input bit expect_out);
        if (expect_out) exp_q.push_back(32'(v));
        send_start();
        send_bits(32'(v), 12);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        ir_signal = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || frame_valid) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    // Sampled mid-low-phase; a pop happens on the following rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (!RST && frame_valid && frame_ready) begin
                if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 1);
                else                   chk("sb_data", 32'(frame_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge CLK);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(frame_data), 0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);

        // 1: basic frame, held at the FIFO head
        frame_ready = 1'b0;
        send_frame(12'hB2B, 1'b1);
        chk("t1_valid", 32'(frame_valid), 1);
        chk("t1_data", 32'(frame_data), 32'h0B2B);
        chk("t1_frames", frame_count, 1);
        chk("t1_errors", 32'(error_count), 0);
        chk("t1_level", 32'(fifo_level), 1);
        frame_ready = 1'b1;
        wait_drained("t1_drain");

        // 2: data pulses without a start pulse are ignored silently
        do_reset();
        send_bits(32'hA, 4);
        chk("t2_errors", 32'(error_count), 0);
        chk("t2_frames", frame_count, 0);
        chk("t2_valid", 32'(frame_valid), 0);
        send_frame(12'h001, 1'b1);
        wait_drained("t2_drain");
        chk("t2_frames2", frame_count, 1);

        // 3a: width-150 bit is accepted, then the long gap abandons the frame
        do_reset();
        send_start();
        send_bits(32'h16, 5);
        drive(1'b0, 150);
        drive(1'b1, 30);
        chk("t3_busy150", 32'(busy), 1);
        chk("t3_err150", 32'(error_count), 0);
        drive(1'b1, 1170);
        chk("t3_err_to", 32'(error_count), 1);
        chk("t3_busy_to", 32'(busy), 0);
        chk("t3_frames", frame_count, 0);

        // 3b: idle timeout straight after five bits
        do_reset();
        send_start();
        send_bits(32'h16, 5);
        drive(1'b1, 1200);
        chk("t3b_err", 32'(error_count), 1);
        chk("t3b_busy", 32'(busy), 0);
        chk("t3b_valid", 32'(frame_valid), 0);

        // 4a: runt pulse inside a frame
        do_reset();
        send_start();
        send_bits(32'h5, 3);
        drive(1'b0, 10);
        drive(1'b1, 30);
        chk("t4a_err", 32'(error_count), 1);
        chk("t4a_busy", 32'(busy), 0);

        // 4b: start pulse mid-frame resynchronises
        do_reset();
        exp_q.push_back(32'h0A5C);
        send_start();
        send_bits(32'h5, 3);
        send_start();
        send_bits(32'hA5C, 12);
        wait_drained("t4b_drain");
        chk("t4b_err", 32'(error_count), 1);
        chk("t4b_frames", frame_count, 1);

        // 5: overflow with the consumer stalled
        do_reset();
        frame_ready = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(12'(1 << f), f < 4);
        chk("t5_level", 32'(fifo_level), 4);
        chk("t5_ovf", 32'(overflow_count), 1);
        chk("t5_head", 32'(frame_data), 32'h001);
        frame_ready = 1'b1;
        wait_drained("t5_drain");
        chk("t5_level0", 32'(fifo_level), 0);

        // 6: asynchronous reset in the middle of a frame
        send_start();
        send_bits(32'h2, 2);
        chk("t6_busy_pre", 32'(busy), 1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_frames", frame_count, 0);
        chk("t6_ovf", 32'(overflow_count), 0);
        chk("t6_level", 32'(fifo_level), 0);
        ir_signal = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        send_frame(12'h3C5, 1'b1);
        wait_drained("t6_drain");
        chk("t6_frames2", frame_count, 1);
        chk("t6_err", 32'(error_count), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
